// File: rtl/color_sched_pkg.sv
// Shared types and constants for color_apply_scheduler: FSM state encoding,
// default datapath widths and reset values.
package color_sched_pkg;

   localparam int COLOR_W_DEF = 32;
   localparam int IDENT_W_DEF = 32;
   localparam int UNIT_W_DEF  = 7;

   typedef logic [2:0] state_t;

   localparam state_t S_IDLE      = 3'd0;
   localparam state_t S_ISSUE_REG = 3'd1;
   localparam state_t S_WAIT_REG  = 3'd2;
   localparam state_t S_ISSUE_VIS = 3'd3;
   localparam state_t S_WAIT_VIS  = 3'd4;
   localparam state_t S_WB_LAST   = 3'd5;

   localparam state_t RST_STATE = S_IDLE;
   localparam logic   RST_BIT   = 1'b0;

   // A resolver result is only legal while a pass is waiting for it.
   function automatic logic is_wait(input state_t s);
      return (s == S_WAIT_REG) || (s == S_WAIT_VIS);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority select starting at the registered pointer; the pointer
// moves past the winner whenever a grant is actually taken.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req,
   input  logic               advance,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               any
);
   logic [ID_W-1:0] ptr_r;

   // First pending requester at or above ptr_r, wrapping.
   always_comb begin
      int idx;
      grant_id = '0;
      any      = 1'b0;
      idx      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr_r) + i;
         if (idx >= NUM_REQ) begin
            idx = idx - NUM_REQ;
         end else begin
            idx = idx;
         end
         if (!any && req[idx[ID_W-1:0]]) begin
            any      = 1'b1;
            grant_id = idx[ID_W-1:0];
         end else begin
            any      = any;
            grant_id = grant_id;
         end
      end
   end

   assign grant = any ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << grant_id) : {NUM_REQ{1'b0}};

   // Pointer update on accept.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_r <= '0;
      end else if (advance) begin
         ptr_r <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      end
   end

endmodule

// File: rtl/color_apply_scheduler.sv
// Shares one color resolver among style-property appliers, one request at a time.
// Define COLOR_SCHED_VISITED_EN to build the visited-link resolution pass.
module color_apply_scheduler
   import color_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int COLOR_W = COLOR_W_DEF,
   parameter int IDENT_W = IDENT_W_DEF,
   parameter int UNIT_W  = UNIT_W_DEF,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*IDENT_W-1:0] req_ident,
   input  logic [NUM_REQ*UNIT_W-1:0]  req_unit_type,
   input  logic [NUM_REQ*COLOR_W-1:0] req_rgbcolor,
   input  logic [NUM_REQ-1:0]         req_apply_regular,
   input  logic [NUM_REQ-1:0]         req_apply_visited,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       res_start,
   output logic [IDENT_W-1:0]         res_ident,
   output logic [UNIT_W-1:0]          res_unit_type,
   output logic [COLOR_W-1:0]         res_rgbcolor,
   output logic                       res_for_visited,
   input  logic                       res_done,
   input  logic [COLOR_W-1:0]         res_color,
   output logic                       wb_valid,
   output logic [ID_W-1:0]            wb_id,
   output logic                       wb_visited,
   output logic [COLOR_W-1:0]         wb_color,
   output logic                       busy,
   output logic                       protocol_err
);
   state_t              state_r, state_nxt_s;
   logic [NUM_REQ-1:0]  grant_s;
   logic [ID_W-1:0]     grant_id_s, cur_id_r, wb_id_r;
   logic                any_s, accept_s, sel_reg_s, sel_vis_s, stray_s, drop_s;
   logic                res_start_r, wb_valid_r, busy_r, protocol_err_r;
   logic [IDENT_W-1:0]  res_ident_r;
   logic [UNIT_W-1:0]   res_unit_type_r;
   logic [COLOR_W-1:0]  res_rgbcolor_r, wb_color_r;

   rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
      .clk      (clk),
      .reset    (reset),
      .req      (req_valid),
      .advance  (accept_s),
      .grant    (grant_s),
      .grant_id (grant_id_s),
      .any      (any_s)
   );

   // Gated by reset so nothing is granted while reset is held.
   assign accept_s  = reset && (state_r == S_IDLE) && any_s;
   assign req_ready = accept_s ? grant_s : {NUM_REQ{1'b0}};
   assign sel_reg_s = req_apply_regular[grant_id_s];
   assign stray_s   = res_done && !is_wait(state_r);
   assign drop_s    = (state_r != S_IDLE) && !req_valid[cur_id_r];

`ifdef COLOR_SCHED_VISITED_EN
   logic apply_vis_r, res_vis_r, wb_visited_r;
   assign sel_vis_s       = req_apply_visited[grant_id_s];
   assign res_for_visited = res_vis_r;
   assign wb_visited      = wb_visited_r;
`else
   logic unused_vis_s;
   assign unused_vis_s    = ^req_apply_visited;
   assign sel_vis_s       = 1'b0;
   assign res_for_visited = 1'b0;
   assign wb_visited      = 1'b0;
`endif

   // Next-state decode.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (accept_s && sel_reg_s)      state_nxt_s = S_ISSUE_REG;
            else if (accept_s && sel_vis_s) state_nxt_s = S_ISSUE_VIS;
            else                            state_nxt_s = S_IDLE;
         end
         S_ISSUE_REG: state_nxt_s = S_WAIT_REG;
         S_WAIT_REG: begin
`ifdef COLOR_SCHED_VISITED_EN
            if (res_done) state_nxt_s = apply_vis_r ? S_ISSUE_VIS : S_WB_LAST;
`else
            if (res_done) state_nxt_s = S_WB_LAST;
`endif
            else          state_nxt_s = S_WAIT_REG;
         end
`ifdef COLOR_SCHED_VISITED_EN
         S_ISSUE_VIS: state_nxt_s = S_WAIT_VIS;
         S_WAIT_VIS: begin
            if (res_done) state_nxt_s = S_WB_LAST;
            else          state_nxt_s = S_WAIT_VIS;
         end
`endif
         S_WB_LAST: state_nxt_s = S_IDLE;
         default:   state_nxt_s = S_IDLE;
      endcase
   end

   // FSM, operand latches, launch strobe and sticky error.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r         <= RST_STATE;
         cur_id_r        <= '0;
         res_ident_r     <= '0;
         res_unit_type_r <= '0;
         res_rgbcolor_r  <= '0;
         res_start_r     <= RST_BIT;
         busy_r          <= RST_BIT;
         protocol_err_r  <= RST_BIT;
      end else begin
         state_r        <= state_nxt_s;
         busy_r         <= (state_nxt_s != S_IDLE);
         res_start_r    <= (state_nxt_s == S_ISSUE_REG) || (state_nxt_s == S_ISSUE_VIS);
         protocol_err_r <= protocol_err_r || stray_s || drop_s;
         if (accept_s) begin
            cur_id_r        <= grant_id_s;
            res_ident_r     <= req_ident[int'(grant_id_s)*IDENT_W +: IDENT_W];
            res_unit_type_r <= req_unit_type[int'(grant_id_s)*UNIT_W +: UNIT_W];
            res_rgbcolor_r  <= req_rgbcolor[int'(grant_id_s)*COLOR_W +: COLOR_W];
         end
      end
   end

   // Write-back register: one pulse per resolved color, one cycle after res_done.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wb_valid_r <= RST_BIT;
         wb_id_r    <= '0;
         wb_color_r <= '0;
      end else begin
         wb_valid_r <= is_wait(state_r) && res_done;
         if (is_wait(state_r) && res_done) begin
            wb_id_r    <= cur_id_r;
            wb_color_r <= res_color;
         end
      end
   end

`ifdef COLOR_SCHED_VISITED_EN
   // Visited-pass bookkeeping.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         apply_vis_r  <= RST_BIT;
         res_vis_r    <= RST_BIT;
         wb_visited_r <= RST_BIT;
      end else begin
         if (accept_s) apply_vis_r <= sel_vis_s;
         res_vis_r <= (state_nxt_s == S_ISSUE_VIS) || (state_nxt_s == S_WAIT_VIS);
         if (is_wait(state_r) && res_done) wb_visited_r <= (state_r == S_WAIT_VIS);
      end
   end
`endif

   assign res_start     = res_start_r;
   assign res_ident     = res_ident_r;
   assign res_unit_type = res_unit_type_r;
   assign res_rgbcolor  = res_rgbcolor_r;
   assign wb_valid      = wb_valid_r;
   assign wb_id         = wb_id_r;
   assign wb_color      = wb_color_r;
   assign busy          = busy_r;
   assign protocol_err  = protocol_err_r;

endmodule

// File: tb/tb_color_apply_scheduler.sv
// Directed bench for color_apply_scheduler; expectations follow the
// COLOR_SCHED_VISITED_EN setting of the build.
module tb_color_apply_scheduler;
   logic         clk = 1'b0;
   logic         reset;
   logic [3:0]   req_valid, req_apply_regular, req_apply_visited, req_ready;
   logic [127:0] req_ident, req_rgbcolor;
   logic [27:0]  req_unit_type;
   logic         res_start, res_for_visited, res_done, wb_valid, wb_visited, busy, protocol_err;
   logic [31:0]  res_ident, res_rgbcolor, res_color, wb_color;
   logic [6:0]   res_unit_type;
   logic [1:0]   wb_id;
   int           checks, failures;

   color_apply_scheduler dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ident(req_ident),
      .req_unit_type(req_unit_type), .req_rgbcolor(req_rgbcolor),
      .req_apply_regular(req_apply_regular), .req_apply_visited(req_apply_visited),
      .req_ready(req_ready), .res_start(res_start), .res_ident(res_ident),
      .res_unit_type(res_unit_type), .res_rgbcolor(res_rgbcolor),
      .res_for_visited(res_for_visited), .res_done(res_done), .res_color(res_color),
      .wb_valid(wb_valid), .wb_id(wb_id), .wb_visited(wb_visited), .wb_color(wb_color),
      .busy(busy), .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   task automatic set_req(input int id, input logic [31:0] ident, input logic [6:0] unit,
                          input logic [31:0] rgb, input logic reg_f, input logic vis_f);
      req_ident[id*32 +: 32]   = ident;
      req_unit_type[id*7 +: 7] = unit;
      req_rgbcolor[id*32 +: 32] = rgb;
      req_apply_regular[id]    = reg_f;
      req_apply_visited[id]    = vis_f;
   endtask

   task automatic test_reset();
      @(negedge clk); reset = 1'b0; req_valid = 4'b1111; #1;
      checks++;
      if ({req_ready, res_start, res_ident, res_unit_type, res_rgbcolor, res_for_visited,
           wb_valid, wb_id, wb_visited, wb_color, busy, protocol_err} !== 116'd0) begin
         failures++; $display("FAIL reset_outputs got nonzero outputs ready=%b busy=%b", req_ready, busy);
      end
      @(negedge clk); req_valid = 4'b0000; reset = 1'b1;
   endtask

   task automatic test_single();
      @(negedge clk);
      set_req(1, 32'h0000_0123, 7'h19, 32'hCAFE_F00D, 1'b1, 1'b0);
      req_valid = 4'b0010; #1;
      checks++;
      if (req_ready !== 4'b0010 || busy !== 1'b0) begin
         failures++; $display("FAIL single_accept got ready=%b busy=%b exp ready=0010 busy=0", req_ready, busy);
      end
      @(negedge clk); #1;
      checks++;
      if (res_start !== 1'b1 || res_for_visited !== 1'b0 || res_ident !== 32'h0000_0123 ||
          res_unit_type !== 7'h19 || res_rgbcolor !== 32'hCAFE_F00D || busy !== 1'b1) begin
         failures++;
         $display("FAIL single_issue got start=%b vis=%b ident=%h unit=%h rgb=%h busy=%b exp 1 0 00000123 19 cafef00d 1",
                  res_start, res_for_visited, res_ident, res_unit_type, res_rgbcolor, busy);
      end
      @(negedge clk); #1;
      checks++;
      if (res_start !== 1'b0) begin
         failures++; $display("FAIL single_start_pulse got=%b exp=0", res_start);
      end
      @(negedge clk);
      @(negedge clk); res_done = 1'b1; res_color = 32'hFF00_00FF; #1;
      checks++;
      if (wb_valid !== 1'b0) begin
         failures++; $display("FAIL single_wb_early got=%b exp=0", wb_valid);
      end
      @(negedge clk); res_done = 1'b0; res_color = 32'h0; #1;
      checks++;
      if (wb_valid !== 1'b1 || wb_id !== 2'd1 || wb_visited !== 1'b0 || wb_color !== 32'hFF00_00FF) begin
         failures++;
         $display("FAIL single_wb got valid=%b id=%0d vis=%b color=%h exp 1 1 0 ff0000ff", wb_valid, wb_id, wb_visited, wb_color);
      end
      @(negedge clk); req_valid = 4'b0000; #1;
      checks++;
      if (busy !== 1'b0 || wb_valid !== 1'b0 || protocol_err !== 1'b0) begin
         failures++; $display("FAIL single_idle got busy=%b wb=%b err=%b exp 0 0 0", busy, wb_valid, protocol_err);
      end
   endtask

   task automatic test_two_pass();
      @(negedge clk);
      set_req(2, 32'h0000_0042, 7'h01, 32'h0102_0304, 1'b1, 1'b1);
      req_valid = 4'b0100; #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         failures++; $display("FAIL two_accept got=%b exp=0100", req_ready);
      end
      @(negedge clk); #1;
      checks++;
      if (res_start !== 1'b1 || res_for_visited !== 1'b0) begin
         failures++; $display("FAIL two_issue_reg got start=%b vis=%b exp 1 0", res_start, res_for_visited);
      end
      @(negedge clk);
      @(negedge clk); res_done = 1'b1; res_color = 32'h1122_3344;
      @(negedge clk); res_done = 1'b0; #1;
      checks++;
      if (wb_valid !== 1'b1 || wb_id !== 2'd2 || wb_visited !== 1'b0 || wb_color !== 32'h1122_3344) begin
         failures++;
         $display("FAIL two_wb_reg got valid=%b id=%0d vis=%b color=%h exp 1 2 0 11223344", wb_valid, wb_id, wb_visited, wb_color);
      end
`ifdef COLOR_SCHED_VISITED_EN
      checks++;
      if (res_start !== 1'b1 || res_for_visited !== 1'b1) begin
         failures++; $display("FAIL two_issue_vis got start=%b vis=%b exp 1 1", res_start, res_for_visited);
      end
      @(negedge clk);
      @(negedge clk); res_done = 1'b1; res_color = 32'h5566_7788;
      @(negedge clk); res_done = 1'b0; #1;
      checks++;
      if (wb_valid !== 1'b1 || wb_visited !== 1'b1 || wb_color !== 32'h5566_7788 || busy !== 1'b1) begin
         failures++;
         $display("FAIL two_wb_vis got valid=%b vis=%b color=%h busy=%b exp 1 1 55667788 1", wb_valid, wb_visited, wb_color, busy);
      end
`else
      checks++;
      if (res_start !== 1'b0 || busy !== 1'b1) begin
         failures++; $display("FAIL two_no_vis_pass got start=%b busy=%b exp 0 1", res_start, busy);
      end
`endif
      @(negedge clk); req_valid = 4'b0000; #1;
      checks++;
      if (busy !== 1'b0 || wb_valid !== 1'b0) begin
         failures++; $display("FAIL two_idle got busy=%b wb=%b exp 0 0", busy, wb_valid);
      end
   endtask

   task automatic test_zero_flags();
      @(negedge clk);
      set_req(3, 32'h0000_0007, 7'h02, 32'hDEAD_BEEF, 1'b0, 1'b0);
      req_valid = 4'b1000; #1;
      checks++;
      if (req_ready !== 4'b1000) begin
         failures++; $display("FAIL zero_accept got=%b exp=1000", req_ready);
      end
      @(negedge clk); req_valid = 4'b0000; #1;
      checks++;
      if (res_start !== 1'b0 || busy !== 1'b0 || wb_valid !== 1'b0) begin
         failures++; $display("FAIL zero_idle got start=%b busy=%b wb=%b exp 0 0 0", res_start, busy, wb_valid);
      end
      @(negedge clk); #1;
      checks++;
      if (wb_valid !== 1'b0 || res_start !== 1'b0 || protocol_err !== 1'b0) begin
         failures++; $display("FAIL zero_quiet got wb=%b start=%b err=%b exp 0 0 0", wb_valid, res_start, protocol_err);
      end
   endtask

   task automatic test_fairness();
      logic [1:0] exp_order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      logic [3:0] exp_ready [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int r = 0; r < 4; r++) set_req(r, 32'h100 + r, 7'h03, 32'hA000_0000 + r, 1'b1, 1'b0);
      @(negedge clk); req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         #1;
         checks++;
         if (req_ready !== exp_ready[k]) begin
            failures++; $display("FAIL fair_grant_%0d got=%b exp=%b", k, req_ready, exp_ready[k]);
         end
         @(negedge clk); #1;
         checks++;
         if (req_ready !== 4'b0000 || res_start !== 1'b1) begin
            failures++; $display("FAIL fair_busy_%0d got ready=%b start=%b exp 0000 1", k, req_ready, res_start);
         end
         @(negedge clk); res_done = 1'b1; res_color = 32'hB000_0000 + k;
         @(negedge clk); res_done = 1'b0; #1;
         checks++;
         if (wb_valid !== 1'b1 || wb_id !== exp_order[k] || wb_color !== 32'hB000_0000 + k) begin
            failures++;
            $display("FAIL fair_wb_%0d got valid=%b id=%0d color=%h exp 1 %0d %h", k, wb_valid, wb_id, wb_color, exp_order[k], 32'hB000_0000 + k);
         end
         @(negedge clk);
      end
      req_valid = 4'b0000;
   endtask

   task automatic test_stray_done();
      @(negedge clk); res_done = 1'b1; res_color = 32'h0BAD_0BAD;
      @(negedge clk); res_done = 1'b0; #1;
      checks++;
      if (protocol_err !== 1'b1 || wb_valid !== 1'b0) begin
         failures++; $display("FAIL stray_done got err=%b wb=%b exp 1 0", protocol_err, wb_valid);
      end
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (protocol_err !== 1'b1 || busy !== 1'b0) begin
         failures++; $display("FAIL stray_sticky got err=%b busy=%b exp 1 0", protocol_err, busy);
      end
   endtask

   task automatic test_reset_mid_wait();
      @(negedge clk); req_valid = 4'b1111; #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         failures++; $display("FAIL rst_pre_grant got=%b exp=0010", req_ready);
      end
      @(negedge clk);
      @(negedge clk); reset = 1'b0; #1;
      checks++;
      if ({req_ready, res_start, res_ident, res_unit_type, res_rgbcolor, res_for_visited,
           wb_valid, wb_id, wb_visited, wb_color, busy, protocol_err} !== 116'd0) begin
         failures++;
         $display("FAIL rst_mid_outputs got ready=%b busy=%b err=%b ident=%h exp all 0", req_ready, busy, protocol_err, res_ident);
      end
      @(negedge clk); res_done = 1'b1; res_color = 32'h7777_7777;
      @(negedge clk); res_done = 1'b0; reset = 1'b1; #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++; $display("FAIL rst_first_grant got=%b exp=0001", req_ready);
      end
      @(negedge clk); #1;
      checks++;
      if (protocol_err !== 1'b0 || wb_valid !== 1'b0 || res_start !== 1'b1 || res_ident !== 32'h100) begin
         failures++;
         $display("FAIL rst_after got err=%b wb=%b start=%b ident=%h exp 0 0 1 00000100", protocol_err, wb_valid, res_start, res_ident);
      end
      req_valid = 4'b0000;
   endtask

   initial begin
      checks = 0; failures = 0;
      reset = 1'b0; req_valid = 4'b0; req_apply_regular = 4'b0; req_apply_visited = 4'b0;
      req_ident = 128'd0; req_rgbcolor = 128'd0; req_unit_type = 28'd0;
      res_done = 1'b0; res_color = 32'd0;
      test_reset();
      test_single();
      test_two_pass();
      test_zero_flags();
      test_fairness();
      test_stray_done();
      test_reset_mid_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout bench did not finish");
      $fatal(1, "timeout");
   end

endmodule
